// File: rtl/sccb_pkg.sv
// Shared encodings for the SCCB master: FSM states, quarter indices, phases.
package sccb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_STOP
  } state_t;

  // Quarter positions inside one symbol (start, bit or stop)
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // PH_ADDR is shared by write and read; a read leaves it through a STOP/START pair
  typedef enum logic [2:0] {
    PH_ID,
    PH_ADDR,
    PH_DATA,
    PH_RID,
    PH_RDATA
  } phase_t;

  // 8 data bits plus the don't-care / NA slot
  localparam int SYM_CNT = 9;

endpackage

// File: rtl/sccb_if.sv
// Command/response handshake and SIO pin bundle between sequencer, master and pads.
interface sccb_if #(
  parameter int ID_W   = 7,
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ID_W-1:0]   cmd_id;
  logic [DATA_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              sio_c;
  logic              sio_d_out;
  logic              sio_d_oe;
  logic              sio_d_in;

  modport master (
    input  cmd_valid, cmd_rw, cmd_id, cmd_addr, cmd_wdata, sio_d_in,
    output cmd_ready, rsp_valid, rsp_rdata, busy, sio_c, sio_d_out, sio_d_oe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_id, cmd_addr, cmd_wdata, sio_d_in,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, sio_c, sio_d_out, sio_d_oe
  );
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-period tick: counts 0..CLK_DIV-1 while enabled, pulses on the last count.
module sccb_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("sccb_tick_gen: CLK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt;

  // Free-running divider, restarted on every accepted command
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (en)        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/sccb_master.sv
// SCCB master: 3-phase write or 2+2-phase read per accepted command, all in clk domain.
module sccb_master import sccb_pkg::*; #(
  parameter int CLK_DIV = 250,
  parameter int ID_W    = 7,
  parameter int DATA_W  = 8
) (
  input logic   clk,
  input logic   reset,
  sccb_if.master bus
);
  localparam int            BW       = $clog2(SYM_CNT);
  localparam logic [BW-1:0] LAST_BIT = BW'(SYM_CNT - 1);

  if (DATA_W != SYM_CNT - 1 || ID_W + 1 != DATA_W) begin : g_bad_w
    $error("sccb_master: ID byte and data must both be SYM_CNT-1 bits");
  end

  state_t            state, state_nx;
  phase_t            phase, phase_nx;
  logic [1:0]        q, q_nx;
  logic [BW-1:0]     bit_idx, bit_nx;
  logic              tick, accept, done, sample;
  logic              sio_c, sio_d_out, sio_d_oe, cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // Command fields are frozen at accept so the caller may change its inputs freely
  logic              l_rw;
  logic [ID_W-1:0]   l_id;
  logic [DATA_W-1:0] l_addr, l_wdata, rdata_sh;
  logic [DATA_W-1:0] cur_byte, cur_shift;

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid && !reset;
  assign accept    = bus.cmd_valid && cmd_ready;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );

  // Byte driven in the current phase; the bit on the wire is the MSB after shifting
  always_comb begin
    cur_byte = '0;
    case (phase)
      PH_ID:   cur_byte = DATA_W'({l_id, 1'b0});
      PH_RID:  cur_byte = DATA_W'({l_id, 1'b1});
      PH_ADDR: cur_byte = l_addr;
      PH_DATA: cur_byte = l_wdata;
      default: cur_byte = '0;
    endcase
  end
  assign cur_shift = cur_byte << bit_idx;

  // Read data is captured on the tick that ends the high-clock quarter Q2
  assign sample = tick && (state == ST_SHIFT) && (q == Q2) &&
                  (phase == PH_RDATA) && (bit_idx != LAST_BIT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= PH_ID;
      q       <= Q0;
      bit_idx <= '0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      q       <= q_nx;
      bit_idx <= bit_nx;
    end
  end

  // Next state and pin levels decoded from state/quarter/slot
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    q_nx      = q;
    bit_nx    = bit_idx;
    done      = 1'b0;
    sio_c     = 1'b1;
    sio_d_out = 1'b1;
    sio_d_oe  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_START;
          phase_nx = PH_ID;
          q_nx     = Q0;
          bit_nx   = '0;
        end
      end
      ST_START: begin
        sio_d_out = (q == Q0) || (q == Q1);
        if (tick) begin
          q_nx = q + 2'd1;
          if (q == Q3) state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sio_c = q[1];
        if (bit_idx == LAST_BIT) begin
          // NA bit of a read is driven high; other 9th bits are released
          sio_d_oe = (phase == PH_RDATA);
        end else if (phase == PH_RDATA) begin
          sio_d_oe = 1'b0;
        end else begin
          sio_d_out = cur_shift[DATA_W-1];
        end
        if (tick) begin
          q_nx = q + 2'd1;
          if (q == Q3) begin
            if (bit_idx == LAST_BIT) begin
              bit_nx = '0;
              case (phase)
                PH_ID:   phase_nx = PH_ADDR;
                PH_ADDR: if (l_rw) state_nx = ST_STOP; else phase_nx = PH_DATA;
                PH_RID:  phase_nx = PH_RDATA;
                default: state_nx = ST_STOP;
              endcase
            end else begin
              bit_nx = bit_idx + BW'(1);
            end
          end
        end
      end
      ST_STOP: begin
        sio_c     = (q != Q0);
        sio_d_out = q[1];
        if (tick) begin
          q_nx = q + 2'd1;
          if (q == Q3) begin
            // A stop after the address of a read is the mid-transaction restart
            if (phase == PH_ADDR) begin
              state_nx = ST_START;
              phase_nx = PH_RID;
            end else begin
              state_nx = ST_IDLE;
              done     = 1'b1;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Command latch, read shifter and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      l_rw      <= 1'b0;
      l_id      <= '0;
      l_addr    <= '0;
      l_wdata   <= '0;
      rdata_sh  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (accept) begin
        l_rw     <= bus.cmd_rw;
        l_id     <= bus.cmd_id;
        l_addr   <= bus.cmd_addr;
        l_wdata  <= bus.cmd_wdata;
        rdata_sh <= '0;
      end
      if (sample) rdata_sh  <= {rdata_sh[DATA_W-2:0], bus.sio_d_in};
      if (done)   rsp_rdata <= l_rw ? rdata_sh : '0;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.busy      = (state != ST_IDLE) || rsp_valid;
  assign bus.sio_c     = sio_c;
  assign bus.sio_d_out = sio_d_out;
  assign bus.sio_d_oe  = sio_d_oe;
endmodule

// File: tb/tb_sccb_master.sv
// Bench: wire-level SCCB decoder + camera model checked against an event-stream reference.
module tb_sccb_master;
  localparam int EV_S = 8;
  localparam int EV_P = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sccb_if #(.ID_W(7), .DATA_W(8)) bus4 ();
  sccb_if #(.ID_W(7), .DATA_W(8)) bus1 ();

  sccb_master #(.CLK_DIV(4), .ID_W(7), .DATA_W(8)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.master));
  sccb_master #(.CLK_DIV(1), .ID_W(7), .DATA_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master));

  int total = 0;
  int bad = 0;

  // Camera model: drives read data and a low acknowledge when the master releases SIO_D
  logic       slave_out = 1'b1;
  logic [7:0] slave_rdata = 8'h00;
  logic       line4;
  assign line4 = bus4.sio_d_oe ? bus4.sio_d_out : slave_out;
  assign bus4.sio_d_in = line4;
  assign bus1.sio_d_in = bus1.sio_d_oe ? bus1.sio_d_out : 1'b1;

  // Wire decoder: SIO_D edge while SIO_C high -> START/STOP, SIO_C rise -> bit {oe,value}
  logic pc = 1'b1, pl = 1'b1, rd_mode = 1'b0;
  int   bit_cnt = 0;
  int   gcnt = 0;
  int   got [0:4095];
  always @(posedge clk) begin
    if (pc && bus4.sio_c && line4 != pl) begin
      if (gcnt < 4096) got[gcnt] <= line4 ? EV_P : EV_S;
      gcnt <= gcnt + 1;
      if (!line4) begin
        bit_cnt <= 0;
        rd_mode <= 1'b0;
      end
    end else if (!pc && bus4.sio_c) begin
      if (gcnt < 4096) got[gcnt] <= int'({bus4.sio_d_oe, line4});
      gcnt <= gcnt + 1;
      if (bit_cnt == 7) rd_mode <= line4;
      bit_cnt <= bit_cnt + 1;
    end
    if (pc && !bus4.sio_c) begin
      if (bit_cnt % 9 == 8)                            slave_out <= 1'b0;
      else if (rd_mode && bit_cnt >= 9 && bit_cnt <= 16) slave_out <= slave_rdata[3'(16 - bit_cnt)];
      else                                             slave_out <= 1'b1;
    end
    pc <= bus4.sio_c;
    pl <= line4;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: expected event stream from the protocol rules
  int exp_q[$];
  int rd_ptr = 0;

  function automatic void exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(2 + int'(b[i]));
    exp_q.push_back(0);
  endfunction

  // A STOP shows as one clock pulse with SIO_D low, then SIO_D rising
  function automatic void exp_stop();
    exp_q.push_back(2);
    exp_q.push_back(EV_P);
  endfunction

  function automatic void exp_txn(input logic rw, input logic [6:0] id,
                                  input logic [7:0] addr, input logic [7:0] wd,
                                  input logic [7:0] rd);
    exp_q.push_back(EV_S);
    exp_byte({id, 1'b0});
    exp_byte(addr);
    if (!rw) begin
      exp_byte(wd);
      exp_stop();
    end else begin
      exp_stop();
      exp_q.push_back(EV_S);
      exp_byte({id, 1'b1});
      for (int i = 7; i >= 0; i--) exp_q.push_back(int'(rd[i]));
      exp_q.push_back(3);
      exp_stop();
    end
  endfunction

  function automatic int quarters(input logic rw);
    int frame = 4 + 4;
    int phase = 9 * 4;
    return rw ? 2 * (frame + 2 * phase) : frame + 3 * phase;
  endfunction

  task automatic check_stream(input string tag);
    int n = gcnt - rd_ptr;
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk({tag, "_ev"}, got[rd_ptr + i], exp_q[i]);
      if (got[rd_ptr + i] !== exp_q[i]) break;
    end
    rd_ptr = gcnt;
    exp_q.delete();
  endtask

  task automatic set4(input logic rw, input logic [6:0] id, input logic [7:0] addr,
                      input logic [7:0] wd);
    bus4.cmd_rw = rw; bus4.cmd_id = id; bus4.cmd_addr = addr; bus4.cmd_wdata = wd;
  endtask

  // Returns at the posedge on which the command is taken
  task automatic wait_acc4();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus4.cmd_ready) break;
    end
    if (k == 1000) chk("accept_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic wait_rsp4(output int lat, output int busy_ok);
    lat = 0;
    busy_ok = 1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus4.busy !== 1'b1) busy_ok = 0;
      if (bus4.rsp_valid) return;
    end
    chk("rsp_timeout", 0, 1);
    lat = -1;
  endtask

  task automatic full4(input string tag, input logic rw, input logic [6:0] id,
                       input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] rd);
    int lat, bok;
    slave_rdata = rd;
    exp_txn(rw, id, addr, wd, rd);
    @(posedge clk); #1;
    set4(rw, id, addr, wd);
    bus4.cmd_valid = 1'b1;
    wait_acc4();
    #1 bus4.cmd_valid = 1'b0;
    wait_rsp4(lat, bok);
    chk({tag, "_latency"}, lat, 4 * quarters(rw));
    chk({tag, "_busy"}, bok, 1);
    chk({tag, "_rdata"}, int'(bus4.rsp_rdata), rw ? int'(rd) : 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_after"}, int'(bus4.busy), 0);
    chk({tag, "_rsp_pulse"}, int'(bus4.rsp_valid), 0);
    check_stream(tag);
  endtask

  initial begin
    int lat, bok, r1, r2, k, no_rsp;
    logic prevc;
    logic rw;
    logic [6:0] id;
    logic [7:0] ad, wd, rd;
    bus4.cmd_valid = 1'b0; set4(1'b0, 7'h0, 8'h0, 8'h0);
    bus1.cmd_valid = 1'b0; bus1.cmd_rw = 1'b0; bus1.cmd_id = '0;
    bus1.cmd_addr = '0; bus1.cmd_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sio_c", int'(bus4.sio_c), 1);
    chk("rst_sio_d", int'(bus4.sio_d_out), 1);
    chk("rst_oe", int'(bus4.sio_d_oe), 1);
    chk("rst_ready", int'(bus4.cmd_ready), 0);
    chk("rst_rsp", int'(bus4.rsp_valid), 0);
    chk("rst_rdata", int'(bus4.rsp_rdata), 0);
    chk("rst_busy", int'(bus4.busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(bus4.cmd_ready), 1);

    // Directed write and read
    full4("wr_dir", 1'b0, 7'h21, 8'h12, 8'h80, 8'h00);
    full4("rd_dir", 1'b1, 7'h21, 8'h0A, 8'h00, 8'h76);

    // Held request with new fields during busy: first txn unaffected, second 1 cycle later
    exp_txn(1'b0, 7'h21, 8'h3C, 8'h5A, 8'h00);
    exp_txn(1'b1, 7'h30, 8'hC3, 8'hFF, 8'h9D);
    slave_rdata = 8'h9D;
    @(posedge clk); #1;
    set4(1'b0, 7'h21, 8'h3C, 8'h5A);
    bus4.cmd_valid = 1'b1;
    wait_acc4();
    #1 set4(1'b1, 7'h30, 8'hC3, 8'hFF);
    wait_rsp4(lat, bok);
    chk("b2b_a_latency", lat, 4 * quarters(1'b0));
    chk("b2b_ready_in_rsp", int'(bus4.cmd_ready), 0);
    @(posedge clk); @(negedge clk);
    chk("b2b_ready_next", int'(bus4.cmd_ready), 1);
    @(posedge clk);
    #1 bus4.cmd_valid = 1'b0;
    wait_rsp4(lat, bok);
    chk("b2b_b_latency", lat, 4 * quarters(1'b1));
    chk("b2b_b_rdata", int'(bus4.rsp_rdata), 8'h9D);
    check_stream("b2b");

    // Randomized transactions
    for (int t = 0; t < 6; t++) begin
      rw = 1'($urandom_range(0, 1));
      id = 7'($urandom_range(0, 127));
      ad = 8'($urandom_range(0, 255));
      wd = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      full4("rand", rw, id, ad, wd, rd);
    end

    // Reset in quarter 50 of a write
    @(posedge clk); #1;
    set4(1'b0, 7'h21, 8'h55, 8'hAA);
    bus4.cmd_valid = 1'b1;
    wait_acc4();
    #1 bus4.cmd_valid = 1'b0;
    repeat (4 * 50 - 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_sio_c", int'(bus4.sio_c), 1);
    chk("midrst_sio_d", int'(bus4.sio_d_out), 1);
    chk("midrst_oe", int'(bus4.sio_d_oe), 1);
    chk("midrst_busy", int'(bus4.busy), 0);
    chk("midrst_ready", int'(bus4.cmd_ready), 0);
    @(posedge clk); #1 reset = 1'b0;
    no_rsp = 1;
    repeat (700) begin
      @(negedge clk);
      if (bus4.rsp_valid) no_rsp = 0;
    end
    chk("midrst_no_rsp", no_rsp, 1);
    rd_ptr = gcnt;
    exp_q.delete();
    full4("after_rst", 1'b0, 7'h21, 8'h6B, 8'hC4, 8'h00);

    // CLK_DIV=1 instance: latency and SIO_C period
    @(posedge clk); #1;
    bus1.cmd_rw = 1'b0; bus1.cmd_id = 7'h42; bus1.cmd_addr = 8'h11; bus1.cmd_wdata = 8'h01;
    bus1.cmd_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus1.cmd_ready) break;
    end
    if (k == 100) chk("div1_accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus1.cmd_valid = 1'b0;
    lat = 0; r1 = -1; r2 = -1; prevc = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!prevc && bus1.sio_c) begin
        if (r1 < 0) r1 = lat;
        else if (r2 < 0) r2 = lat;
      end
      prevc = bus1.sio_c;
      if (bus1.rsp_valid) break;
    end
    chk("div1_latency", lat, quarters(1'b0));
    chk("div1_sioc_period", r2 - r1, 4);
    chk("div1_rdata", int'(bus1.rsp_rdata), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
